nonce_block_gen: RTL and testbench

// - Upstream feeder for the sha256 compression stage. Builds the padded second
//   512-bit block of an 80-byte Bitcoin header, one candidate nonce per block.
// - Walks a programmed nonce range. Presents each block on a valid/ready handshake

---
 rtl/nonce_block_gen_if.sv | 22 ++
 rtl/nonce_block_gen.sv | 98 +++++++++
 tb/tb_nonce_block_gen.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nonce_block_gen_if.sv
// Block handshake between the nonce block generator and the sha256 stage.
// The master presents a padded 512-bit block plus its nonce tag.
interface nonce_block_gen_if;
    logic         blk_valid;
    logic         blk_ready;
    logic [0:511] unhashed_value;
    logic [31:0]  blk_nonce;

    modport master (
        output blk_valid,
        output unhashed_value,
        output blk_nonce,
        input  blk_ready
    );

    modport slave (
        input  blk_valid,
        input  unhashed_value,
        input  blk_nonce,
        output blk_ready
    );
endinterface

// File: rtl/nonce_block_gen.sv
// Builds padded second blocks of an 80-byte header, one nonce per block.
// Define NONCE_BSWAP_EN to place the nonce byte-swapped in the block.
module nonce_block_gen #(
    parameter logic [31:0] NONCE_STEP = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [95:0] header_tail,
    input  logic [31:0] nonce_start,
    input  logic [31:0] nonce_count,
    output logic        busy,
    output logic        done,
    nonce_block_gen_if.master blk
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e       state_q, state_d;
    logic [95:0]  tail_q, tail_d;
    logic [31:0]  cur_q, cur_d;
    logic [31:0]  remain_q, remain_d;
    logic [0:511] value_q, value_d;
    logic [31:0]  nonce_q;
    logic [31:0]  field_d;
    logic         xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tail_q   <= '0;
            cur_q    <= '0;
            remain_q <= '0;
            value_q  <= '0;
            nonce_q  <= '0;
        end else begin
            state_q  <= state_d;
            tail_q   <= tail_d;
            cur_q    <= cur_d;
            remain_q <= remain_d;
            value_q  <= value_d;
            nonce_q  <= cur_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tail_d   = tail_q;
        cur_d    = cur_q;
        remain_d = remain_q;
        xfer     = (state_q == S_RUN) && blk.blk_ready;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tail_d   = header_tail;
                    cur_d    = nonce_start;
                    remain_d = nonce_count;
                    state_d  = (nonce_count == 32'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    cur_d    = cur_q + NONCE_STEP;
                    remain_d = remain_q - 32'd1;
                end
                // stop wins over range exhaustion: aborted runs never pulse done
                if (stop) begin
                    state_d = S_IDLE;
                end else if (xfer && remain_q == 32'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef NONCE_BSWAP_EN
    assign field_d = {cur_d[7:0], cur_d[15:8], cur_d[23:16], cur_d[31:24]};
`else
    assign field_d = cur_d;
`endif

    // Built from next-state values so the block tracks cur with no lag
    assign value_d = {tail_d, field_d, 32'h8000_0000, 288'b0, 64'd640};

    assign blk.blk_valid      = (state_q == S_RUN);
    assign blk.unhashed_value = value_q;
    assign blk.blk_nonce      = nonce_q;
    assign busy               = (state_q == S_RUN);
    assign done               = (state_q == S_DONE);

endmodule

// File: tb/tb_nonce_block_gen.sv
// Directed self-checking bench for nonce_block_gen.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_nonce_block_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [95:0] header_tail;
    logic [31:0] nonce_start;
    logic [31:0] nonce_count;
    logic        busy;
    logic        done;
    int          checks;
    int          failures;

    nonce_block_gen_if bif ();

    nonce_block_gen dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .header_tail (header_tail),
        .nonce_start (nonce_start),
        .nonce_count (nonce_count),
        .busy        (busy),
        .done        (done),
        .blk         (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_field(input logic [31:0] n);
`ifdef NONCE_BSWAP_EN
        return {n[7:0], n[15:8], n[23:16], n[31:24]};
`else
        return n;
`endif
    endfunction

    task automatic launch(input logic [31:0] ns, input logic [31:0] cnt);
        nonce_start = ns;
        nonce_count = cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if (bif.blk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outs got v=%b b=%b d=%b want 0/0/0",
                     bif.blk_valid, busy, done);
        end
        checks++;
        if (bif.unhashed_value !== 512'b0 || bif.blk_nonce !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got nonce=%h want 0 and zero block",
                     bif.blk_nonce);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // rst mid-run with ready high
        bif.blk_ready = 1'b1;
        launch(32'h100, 32'd10);
        @(negedge clk);
        checks++;
        if (bif.blk_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_prerun got v=%b b=%b want 1/1",
                     bif.blk_valid, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bif.blk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_async got v=%b b=%b d=%b want 0/0/0",
                     bif.blk_valid, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        launch(32'h200, 32'd1);
        checks++;
        if (bif.blk_valid !== 1'b1 || bif.blk_nonce !== 32'h200) begin
            failures++;
            $display("FAIL reset_restart got v=%b n=%h want 1/00000200",
                     bif.blk_valid, bif.blk_nonce);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || bif.blk_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_restart_done got d=%b v=%b want 1/0",
                     done, bif.blk_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [0:511] v;
        header_tail = 96'hA1A2A3A4_B1B2B3B4_C1C2C3C4;
        bif.blk_ready = 1'b1;
        launch(32'h10, 32'd3);
        for (int i = 0; i < 3; i++) begin
            v = bif.unhashed_value;
            checks++;
            if (bif.blk_valid !== 1'b1 || busy !== 1'b1 ||
                bif.blk_nonce !== 32'h10 + i) begin
                failures++;
                $display("FAIL basic_blk%0d got v=%b b=%b n=%h want 1/1/%h",
                         i, bif.blk_valid, busy, bif.blk_nonce, 32'h10 + i);
            end
            checks++;
            if (v[0:95] !== 96'hA1A2A3A4_B1B2B3B4_C1C2C3C4 ||
                v[96:127] !== exp_field(32'h10 + i)) begin
                failures++;
                $display("FAIL basic_head%0d got tail=%h field=%h want field=%h",
                         i, v[0:95], v[96:127], exp_field(32'h10 + i));
            end
            checks++;
            if (v[128:159] !== 32'h8000_0000 || v[160:447] !== 288'b0 ||
                v[448:511] !== 64'd640) begin
                failures++;
                $display("FAIL basic_pad%0d got w4=%h len=%h want 80000000/280",
                         i, v[128:159], v[448:511]);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || bif.blk_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done got d=%b v=%b b=%b want 1/0/0",
                     done, bif.blk_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || bif.blk_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle got d=%b v=%b b=%b want 0/0/0",
                     done, bif.blk_valid, busy);
        end
    endtask

    task automatic test_backpressure;
        logic [3:0]  rdy;
        logic [31:0] want;
        int          xfers;
        rdy = 4'b1001;
        xfers = 0;
        bif.blk_ready = 1'b1;
        launch(32'h55, 32'd2);
        for (int i = 0; i < 4; i++) begin
            want = (i == 0) ? 32'h55 : 32'h56;
            bif.blk_ready = rdy[3-i];
            checks++;
            if (bif.blk_valid !== 1'b1 || bif.blk_nonce !== want ||
                bif.unhashed_value[96:127] !== exp_field(want)) begin
                failures++;
                $display("FAIL bp_hold%0d got v=%b n=%h want 1/%h",
                         i, bif.blk_valid, bif.blk_nonce, want);
            end
            if (bif.blk_valid && bif.blk_ready) xfers++;
            @(negedge clk);
        end
        checks++;
        if (xfers !== 2 || done !== 1'b1 || bif.blk_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_done got xfers=%0d d=%b v=%b want 2/1/0",
                     xfers, done, bif.blk_valid);
        end
        bif.blk_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_wrap;
        logic [31:0] want;
        bif.blk_ready = 1'b1;
        launch(32'hFFFF_FFFE, 32'd3);
        for (int i = 0; i < 3; i++) begin
            want = 32'hFFFF_FFFE + i;
            checks++;
            if (bif.blk_valid !== 1'b1 || bif.blk_nonce !== want ||
                bif.unhashed_value[96:127] !== exp_field(want)) begin
                failures++;
                $display("FAIL wrap_blk%0d got v=%b n=%h want 1/%h",
                         i, bif.blk_valid, bif.blk_nonce, want);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || bif.blk_valid !== 1'b0) begin
            failures++;
            $display("FAIL wrap_done got d=%b v=%b want 1/0", done, bif.blk_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_count;
        bif.blk_ready = 1'b1;
        launch(32'h77, 32'd0);
        checks++;
        if (done !== 1'b1 || bif.blk_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_done got d=%b v=%b b=%b want 1/0/0",
                     done, bif.blk_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || bif.blk_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_idle got d=%b v=%b want 0/0", done, bif.blk_valid);
        end
    endtask

    task automatic test_stop;
        int xfers;
        xfers = 0;
        bif.blk_ready = 1'b1;
        launch(32'h1000, 32'd100);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bif.blk_valid !== 1'b1 || bif.blk_nonce !== 32'h1000 + i) begin
                failures++;
                $display("FAIL stop_blk%0d got v=%b n=%h want 1/%h",
                         i, bif.blk_valid, bif.blk_nonce, 32'h1000 + i);
            end
            if (bif.blk_valid && bif.blk_ready) xfers++;
            if (i == 4) stop = 1'b1;
            @(negedge clk);
        end
        stop = 1'b0;
        checks++;
        if (xfers !== 5 || bif.blk_valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0) begin
            failures++;
            $display("FAIL stop_halt got x=%0d v=%b b=%b d=%b want 5/0/0/0",
                     xfers, bif.blk_valid, busy, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || bif.blk_valid !== 1'b0) begin
            failures++;
            $display("FAIL stop_nodone got d=%b v=%b want 0/0", done, bif.blk_valid);
        end
        launch(32'h1234_5678, 32'd1);
        checks++;
        if (bif.blk_valid !== 1'b1 || bif.blk_nonce !== 32'h1234_5678 ||
            bif.unhashed_value[96:127] !== exp_field(32'h1234_5678)) begin
            failures++;
            $display("FAIL stop_restart got v=%b n=%h f=%h want 1/12345678/%h",
                     bif.blk_valid, bif.blk_nonce, bif.unhashed_value[96:127],
                     exp_field(32'h1234_5678));
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL stop_restart_done got d=%b want 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_field;
`ifdef NONCE_BSWAP_EN
        logic [31:0] want;
        want = 32'h7856_3412;
`else
        logic [31:0] want;
        want = 32'h1234_5678;
`endif
        bif.blk_ready = 1'b0;
        launch(32'h1234_5678, 32'd1);
        checks++;
        if (bif.unhashed_value[96:127] !== want ||
            bif.blk_nonce !== 32'h1234_5678) begin
            failures++;
            $display("FAIL field got f=%h n=%h want %h/12345678",
                     bif.unhashed_value[96:127], bif.blk_nonce, want);
        end
        bif.blk_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        header_tail = 96'h0;
        nonce_start = 32'h0;
        nonce_count = 32'h0;
        bif.blk_ready = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_backpressure;
        test_wrap;
        test_zero_count;
        test_stop;
        test_field;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
